// File: rtl/ss_addresses_pkg.sv
// Shared savestate bus definitions: word/address widths, the idle address
// and the bus controller state encoding.
package ss_addresses;

    localparam int SS_DATA_WIDTH = 32;
    localparam int SS_BUS_WIDTH  = 8;

    // All ones never decodes to a real responder, so parking here means "no access".
    localparam logic [SS_BUS_WIDTH-1:0] SS_IDLE_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETTLE,
        RD_EMIT,
        WR_WAIT,
        WR_SETTLE,
        RS_SETTLE
    } ss_ctrl_state_t;

endpackage

// File: rtl/ss_bus_controller_if.sv
// Host stream and responder bus signals of the savestate bus controller.
// master = controller side, slave = host plumbing plus responders.
interface ss_bus_controller_if;
    import ss_addresses::*;

    logic [SS_DATA_WIDTH-1:0] save_data;
    logic                     save_valid;
    logic                     save_ready;
    logic [SS_DATA_WIDTH-1:0] load_data;
    logic                     load_valid;
    logic                     load_ready;
    logic [SS_BUS_WIDTH-1:0]  bus_addr;
    logic [SS_DATA_WIDTH-1:0] bus_in;
    logic                     bus_wren;
    logic                     bus_reset_n;
    logic [SS_DATA_WIDTH-1:0] bus_out;

    modport master (
        output save_data, save_valid,
        input  save_ready,
        input  load_data, load_valid,
        output load_ready,
        output bus_addr, bus_in, bus_wren, bus_reset_n,
        input  bus_out
    );

    modport slave (
        input  save_data, save_valid,
        output save_ready,
        output load_data, load_valid,
        input  load_ready,
        input  bus_addr, bus_in, bus_wren, bus_reset_n,
        output bus_out
    );

endinterface

// File: rtl/ss_bus_controller_settle_timer.sv
// Settle timer shared by every settle state of the bus controller.
// A load pulse arms it with SETTLE_CYCLES; o_expired marks the final settle cycle.
module ss_settle_timer #(
    parameter int SETTLE_CYCLES = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    output logic o_expired
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VALUE = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic [CW-1:0] r_count;

    // Down-counter: reload on i_load, otherwise count towards zero and rest there.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VALUE;
        end else if (r_count != '0) begin
            r_count <= r_count - ONE;
        end
    end

    // Loaded in the cycle the settle state is entered, so a count of one is its last cycle.
    assign o_expired = (r_count == ONE);

endmodule

// File: rtl/ss_bus_controller.sv
// Savestate bus initiator: walks addresses 0..ADDRESS_COUNT-1 to save words out,
// load words in, or restore responder defaults. All outputs are registered.
module ss_bus_controller
    import ss_addresses::*;
#(
    parameter int ADDRESS_COUNT = 64,
    parameter int SETTLE_CYCLES = 12
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       save_start,
    input  logic                       load_start,
    input  logic                       restore_start,
    output logic                       busy,
    output logic                       done,
    ss_bus_controller_if.master        bus
);

    localparam logic [SS_BUS_WIDTH-1:0] LAST_ADDR = SS_BUS_WIDTH'(ADDRESS_COUNT - 1);
    localparam logic [SS_BUS_WIDTH-1:0] ADDR_ONE  = SS_BUS_WIDTH'(1);

    ss_ctrl_state_t           r_state,        w_state_next;
    logic [SS_BUS_WIDTH-1:0]  r_addr,         w_addr_next;
    logic [SS_DATA_WIDTH-1:0] r_save_data,    w_save_data_next;
    logic [SS_DATA_WIDTH-1:0] r_bus_in,       w_bus_in_next;
    logic [SS_BUS_WIDTH-1:0]  r_bus_addr,     w_bus_addr_next;
    logic                     r_busy,         w_busy_next;
    logic                     r_done,         w_done_next;
    logic                     r_save_valid,   w_save_valid_next;
    logic                     r_load_ready,   w_load_ready_next;
    logic                     r_bus_wren,     w_bus_wren_next;
    logic                     r_bus_reset_n,  w_bus_reset_n_next;
    logic                     w_timer_load;
    logic                     w_expired;
    logic                     w_last;

    assign w_last = (r_addr == LAST_ADDR);

    ss_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_timer_load),
        .o_expired (w_expired)
    );

    // Next-state, address and datapath decisions for the walk.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a value unassigned (no latch).
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_save_data_next = r_save_data;
        w_bus_in_next    = r_bus_in;
        w_done_next      = 1'b0;
        w_timer_load     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (save_start) begin
                    w_state_next = RD_SETTLE;
                    w_addr_next  = '0;
                    w_timer_load = 1'b1;
                end else if (load_start) begin
                    w_state_next = WR_WAIT;
                    w_addr_next  = '0;
                end else if (restore_start) begin
                    w_state_next = RS_SETTLE;
                    w_addr_next  = '0;
                    w_timer_load = 1'b1;
                end
            end
            RD_SETTLE: begin
                if (w_expired) begin
                    w_save_data_next = bus.bus_out;
                    w_state_next     = RD_EMIT;
                end
            end
            RD_EMIT: begin
                if (r_save_valid && bus.save_ready) begin
                    if (w_last) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_addr_next  = r_addr + ADDR_ONE;
                        w_state_next = RD_SETTLE;
                        w_timer_load = 1'b1;
                    end
                end
            end
            WR_WAIT: begin
                if (r_load_ready && bus.load_valid) begin
                    w_bus_in_next = bus.load_data;
                    w_state_next  = WR_SETTLE;
                    w_timer_load  = 1'b1;
                end
            end
            WR_SETTLE: begin
                if (w_expired) begin
                    if (w_last) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_addr_next  = r_addr + ADDR_ONE;
                        w_state_next = WR_WAIT;
                    end
                end
            end
            RS_SETTLE: begin
                if (w_expired) begin
                    if (w_last) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_addr_next  = r_addr + ADDR_ONE;
                        w_timer_load = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output values decoded from the state being entered, so they register alongside it.
    always_comb begin
        w_busy_next        = (w_state_next != IDLE);
        w_save_valid_next  = (w_state_next == RD_EMIT);
        w_load_ready_next  = (w_state_next == WR_WAIT);
        w_bus_wren_next    = (w_state_next == WR_SETTLE);
        w_bus_reset_n_next = (w_state_next != RS_SETTLE);
        w_bus_addr_next    = SS_IDLE_ADDR;
        if (w_state_next inside {RD_SETTLE, RD_EMIT, WR_SETTLE, RS_SETTLE}) begin
            w_bus_addr_next = w_addr_next;
        end
    end

    // State, address and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_save_data   <= '0;
            r_bus_in      <= '0;
            r_bus_addr    <= SS_IDLE_ADDR;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_save_valid  <= 1'b0;
            r_load_ready  <= 1'b0;
            r_bus_wren    <= 1'b0;
            r_bus_reset_n <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_addr        <= w_addr_next;
            r_save_data   <= w_save_data_next;
            r_bus_in      <= w_bus_in_next;
            r_bus_addr    <= w_bus_addr_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_save_valid  <= w_save_valid_next;
            r_load_ready  <= w_load_ready_next;
            r_bus_wren    <= w_bus_wren_next;
            r_bus_reset_n <= w_bus_reset_n_next;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign bus.save_data   = r_save_data;
    assign bus.save_valid  = r_save_valid;
    assign bus.load_ready  = r_load_ready;
    assign bus.bus_addr    = r_bus_addr;
    assign bus.bus_in      = r_bus_in;
    assign bus.bus_wren    = r_bus_wren;
    assign bus.bus_reset_n = r_bus_reset_n;

endmodule
